mem_stage_responder: RTL and testbench
======================================

Name: mem_stage_responder

Overview:
- Memory-stage responder that services the load/store requests issued by the execute stage.
- Takes the ALU result as the byte address and the Rm value as store data, then performs a multi-cycle access to a word-addressed data memory inside the block.
- Drives freeze back to the pipeline so that the upstream stages hold their state until the access completes.
- Sits between the execute-stage output and the memory/write-back pipeline register.

Parameters:
- DEPTH, 64: number of 32-bit words in the data memory; power of two, at least 2.
- BASE_ADDR, 1024: byte address that maps to word 0.
- WAIT_CYCLES, 3: BUSY cycles per access; at least 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_read_enable  input  1  load request; held stable by the pipeline while freeze=1.
- mem_write_enable  input  1  store request; held stable while freeze=1.
- alu_out  input  32  byte address from the execute stage.
- Val_Rm  input  32  store data.
- mem_result  output  32  load data; registered.
- mem_valid  output  1  one-cycle pulse when an access completes; registered.
- freeze  output  1  stall request to the pipeline; combinational.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, mem_result=0, mem_valid=0.
  - freeze is 0 once state=IDLE and no enable is asserted.
  - Memory array contents are not reset.
- Enable:
  - en = mem_read_enable | mem_write_enable.
  - If both are set, the access is a store and mem_result is unchanged.
- Word index:
  - idx = ((alu_out - BASE_ADDR) >> 2) modulo DEPTH, computed in 32-bit unsigned arithmetic.
  - alu_out[1:0] is ignored, so misaligned addresses are truncated.
  - Addresses below BASE_ADDR or beyond DEPTH words wrap modulo DEPTH. There is no error output.
- States:
  - IDLE:
    - freeze = en.
    - If en: load cnt = WAIT_CYCLES-1 and go to BUSY.
  - BUSY:
    - freeze = 1.
    - If en=0 (aborted request): go to IDLE, no memory write, mem_result unchanged.
    - Else if cnt != 0: decrement cnt.
    - Else (cnt == 0): perform the access on this edge, assert mem_valid=1 next cycle, go to DONE.
      - Store: mem[idx] <= Val_Rm.
      - Load: mem_result <= mem[idx].
  - DONE:
    - freeze = 0 and mem_valid = 1 for exactly this cycle; the pipeline advances at the end of it.
    - Next state is IDLE regardless of en.
    - A new request is therefore recognised no earlier than the following cycle.
- Latency:
  - Counted from the first cycle en=1 in IDLE, freeze is high for WAIT_CYCLES+1 cycles.
  - mem_valid is high in cycle WAIT_CYCLES+1 (0-based).
  - mem_result holds the load data from that cycle until the next completed load.
- Back-to-back requests: each one takes WAIT_CYCLES+2 cycles (IDLE, BUSY×W, DONE). Accesses do not overlap or pipeline.
- Read-after-write to the same index returns the newly stored data, because the accesses are strictly sequential.
- mem_valid is 0 in IDLE and BUSY.
- Reset mid-operation: the access in progress is discarded. A store whose final BUSY edge has not occurred does not modify memory.
- freeze has no path from mem_result. It is a function only of state and en, so no combinational loop is created through the pipeline.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - default BASE_ADDR constant.
  - index-width function, clog2(DEPTH).
- One sub-module, mem_wait_counter:
  - loadable down-counter with load, dec and zero flag, and asynchronous active-low reset.
  - width clog2(WAIT_CYCLES)+1.
- The FSM, address mapping and memory array live in mem_stage_responder.

Test Plan (defaults: DEPTH=64, BASE_ADDR=1024, WAIT_CYCLES=3):
- Store then load:
  - Stimulus: write 0xDEADBEEF to 1028, held until freeze falls; then read 1028.
  - Response: freeze high for 4 cycles on each access; mem_valid pulses in cycle 4; mem_result=0xDEADBEEF.
- Address wrap and misalignment:
  - Stimulus: write 0x11 to 1024, then read 1024+256 (idx wraps to 0), then read 1027.
  - Response: both reads return 0x11.
- Abort:
  - Stimulus: assert write of 0x55 to 1032; deassert en in the second BUSY cycle; then read 1032.
  - Response: freeze drops to 0 the cycle after the abort; the read returns the prior contents, not 0x55.
- Reset mid-operation:
  - Stimulus: pull rst low during a BUSY store of 0x77 to 1036; release; read 1036.
  - Response: outputs go to 0 immediately on reset; state=IDLE; the read returns the prior contents, not 0x77.
- Simultaneous read and write, then back-to-back:
  - Stimulus: both enables set with Val_Rm=0x99 at 1040; then two reads held continuously.
  - Response: the first access stores 0x99 and leaves mem_result unchanged; the two reads complete 5 cycles apart, each with one mem_valid pulse.
- Idle:
  - Stimulus: en=0 for 10 cycles after reset.
  - Response: freeze=0, mem_valid=0, mem_result=0 throughout.

Source files
------------

// File: rtl/mem_stage_responder_pkg.sv
// Shared definitions for the memory-stage responder: FSM encoding, default
// address map base and index-width helper.
package mem_stage_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_DONE    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    function automatic int unsigned idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that paces the BUSY phase of a memory access.
module mem_wait_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins over decrement; the count saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != WIDTH'(0))) begin
            cnt_d = cnt_q - WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= WIDTH'(0);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == WIDTH'(0));

endmodule

// File: rtl/mem_stage_responder.sv
// Memory-stage responder: multi-cycle load/store into a local word array,
// stalling the pipeline via freeze until the access completes.
module mem_stage_responder
    import mem_stage_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_enable,
    input  logic        mem_write_enable,
    input  logic [31:0] alu_out,
    input  logic [31:0] Val_Rm,
    output logic [31:0] mem_result,
    output logic        mem_valid,
    output logic        freeze
);

    localparam int unsigned IDX_W = idx_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES) + 1;

    state_e            state_q;
    logic [31:0]       mem_result_q;
    logic              mem_valid_q;
    logic [31:0]       mem_q [DEPTH];

    logic              en_s;
    logic [31:0]       diff_s;
    logic [IDX_W-1:0]  idx_s;
    logic              unused_addr_s;
    logic              cnt_zero_s;
    logic              cnt_load_s;
    logic              cnt_dec_s;
    logic              access_s;
    logic              store_s;
    logic              freeze_s;

    assign en_s   = mem_read_enable | mem_write_enable;
    // DEPTH is a power of two, so the modulo is a plain truncation of the word offset.
    assign diff_s = alu_out - BASE_ADDR;
    assign idx_s  = diff_s[IDX_W+1:2];
    assign unused_addr_s = ^{diff_s[31:IDX_W+2], diff_s[1:0]};

    assign cnt_load_s = (state_q == ST_IDLE) && en_s;
    assign cnt_dec_s  = (state_q == ST_BUSY) && en_s && !cnt_zero_s;
    assign access_s   = (state_q == ST_BUSY) && en_s && cnt_zero_s;
    assign store_s    = access_s && mem_write_enable;

    mem_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait_counter (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (cnt_load_s),
        .load_val_i (CNT_W'(WAIT_CYCLES - 1)),
        .dec_i      (cnt_dec_s),
        .zero_o     (cnt_zero_s)
    );

    // Data array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (store_s) begin
            mem_q[idx_s] <= Val_Rm;
        end
    end

    // Access sequencing FSM with registered load data and completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            mem_result_q <= 32'd0;
            mem_valid_q  <= 1'b0;
        end else begin
            mem_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (en_s) begin
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!en_s) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_zero_s) begin
                        if (!mem_write_enable) begin
                            mem_result_q <= mem_q[idx_s];
                        end
                        mem_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall request depends only on state and enables, never on load data.
    always_comb begin
        freeze_s = 1'b0;
        case (state_q)
            ST_IDLE: freeze_s = en_s;
            ST_BUSY: freeze_s = 1'b1;
            ST_DONE: freeze_s = 1'b0;
            default: freeze_s = 1'b0;
        endcase
    end

    assign freeze     = freeze_s;
    assign mem_result = mem_result_q;
    assign mem_valid  = mem_valid_q;

endmodule

// File: tb/tb_mem_stage_responder.sv
// Directed self-checking bench for mem_stage_responder (default parameters).
module tb_mem_stage_responder;

    logic        clk;
    logic        rst;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] alu_out;
    logic [31:0] Val_Rm;
    logic [31:0] mem_result;
    logic        mem_valid;
    logic        freeze;

    int tests_run;
    int tests_failed;

    mem_stage_responder dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .alu_out          (alu_out),
        .Val_Rm           (Val_Rm),
        .mem_result       (mem_result),
        .mem_valid        (mem_valid),
        .freeze           (freeze)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request held until completion; reports freeze length,
    // 0-based cycle of the mem_valid pulse (-1 on timeout) and sampled result.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, output int fz_cycles,
                             output int valid_cycle, output logic [31:0] result);
        fz_cycles   = 0;
        valid_cycle = -1;
        result      = 32'hxxxx_xxxx;
        @(posedge clk); #1;
        mem_read_enable  = rd;
        mem_write_enable = wr;
        alu_out          = addr;
        Val_Rm           = data;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (freeze === 1'b1) fz_cycles++;
            if (mem_valid === 1'b1) begin
                valid_cycle = k;
                result      = mem_result;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        mem_read_enable = 1'b0; mem_write_enable = 1'b0;
        alu_out = 32'd0; Val_Rm = 32'd0;
        #23;
        tests_run++;
        if (mem_result !== 32'd0 || mem_valid !== 1'b0 || freeze !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got result=%h valid=%b freeze=%b, want 0/0/0",
                     mem_result, mem_valid, freeze);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_idle;
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (freeze !== 1'b0 || mem_valid !== 1'b0 || mem_result !== 32'd0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL idle_quiet: %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_store_load;
        int fz, vc;
        logic [31:0] res;
        do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, fz, vc, res);
        tests_run++;
        if (fz !== 4) begin tests_failed++; $display("FAIL store_freeze_len: got %0d want 4", fz); end
        tests_run++;
        if (vc !== 4) begin tests_failed++; $display("FAIL store_valid_cycle: got %0d want 4", vc); end
        do_access(1'b1, 1'b0, 32'd1028, 32'd0, fz, vc, res);
        tests_run++;
        if (fz !== 4) begin tests_failed++; $display("FAIL load_freeze_len: got %0d want 4", fz); end
        tests_run++;
        if (vc !== 4) begin tests_failed++; $display("FAIL load_valid_cycle: got %0d want 4", vc); end
        tests_run++;
        if (res !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load_data: got %h want deadbeef", res); end
        #1;
        tests_run++;
        if (mem_valid !== 1'b0 || mem_result !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL valid_pulse_hold: got valid=%b result=%h want 0/deadbeef", mem_valid, mem_result);
        end
    endtask

    task automatic test_wrap;
        int fz, vc;
        logic [31:0] res;
        do_access(1'b0, 1'b1, 32'd1024, 32'h11, fz, vc, res);
        do_access(1'b1, 1'b0, 32'd1280, 32'd0, fz, vc, res);
        tests_run++;
        if (res !== 32'h11 || vc !== 4) begin
            tests_failed++;
            $display("FAIL wrap_read: got %h (cycle %0d) want 00000011 (cycle 4)", res, vc);
        end
        do_access(1'b1, 1'b0, 32'd1027, 32'd0, fz, vc, res);
        tests_run++;
        if (res !== 32'h11 || vc !== 4) begin
            tests_failed++;
            $display("FAIL misaligned_read: got %h (cycle %0d) want 00000011 (cycle 4)", res, vc);
        end
    endtask

    task automatic test_abort;
        int fz, vc;
        logic [31:0] res;
        do_access(1'b0, 1'b1, 32'd1032, 32'hA5, fz, vc, res);
        @(posedge clk); #1;
        mem_write_enable = 1'b1; alu_out = 32'd1032; Val_Rm = 32'h55;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_write_enable = 1'b0;
        #1;
        tests_run++;
        if (freeze !== 1'b1) begin tests_failed++; $display("FAIL abort_busy_freeze: got %b want 1", freeze); end
        @(posedge clk); #2;
        tests_run++;
        if (freeze !== 1'b0 || mem_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_release: got freeze=%b valid=%b want 0/0", freeze, mem_valid);
        end
        do_access(1'b1, 1'b0, 32'd1032, 32'd0, fz, vc, res);
        tests_run++;
        if (res !== 32'hA5) begin tests_failed++; $display("FAIL abort_no_write: got %h want 000000a5", res); end
    endtask

    task automatic test_reset_mid;
        int fz, vc;
        logic [31:0] res;
        do_access(1'b0, 1'b1, 32'd1036, 32'h33, fz, vc, res);
        @(posedge clk); #1;
        mem_write_enable = 1'b1; alu_out = 32'd1036; Val_Rm = 32'h77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_write_enable = 1'b0;
        #1;
        tests_run++;
        if (mem_result !== 32'd0 || mem_valid !== 1'b0 || freeze !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got result=%h valid=%b freeze=%b want 0/0/0",
                     mem_result, mem_valid, freeze);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        do_access(1'b1, 1'b0, 32'd1036, 32'd0, fz, vc, res);
        tests_run++;
        if (res !== 32'h33 || vc !== 4) begin
            tests_failed++;
            $display("FAIL midreset_no_write: got %h (cycle %0d) want 00000033 (cycle 4)", res, vc);
        end
    endtask

    task automatic test_back_to_back;
        int fz, vc, pulses, first_c, second_c;
        logic [31:0] res, r1, r2;
        do_access(1'b1, 1'b1, 32'd1040, 32'h99, fz, vc, res);
        tests_run++;
        if (vc !== 4 || res !== 32'h33) begin
            tests_failed++;
            $display("FAIL both_en_result: got %h (cycle %0d) want 00000033 (cycle 4)", res, vc);
        end
        pulses = 0; first_c = -1; second_c = -1; r1 = 32'd0; r2 = 32'd0;
        @(posedge clk); #1;
        mem_read_enable = 1'b1; alu_out = 32'd1040;
        for (int k = 0; k < 15; k++) begin
            if (k == 10) mem_read_enable = 1'b0;
            #1;
            if (mem_valid === 1'b1) begin
                pulses++;
                if (first_c < 0) begin first_c = k; r1 = mem_result; end
                else begin second_c = k; r2 = mem_result; end
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (pulses !== 2) begin tests_failed++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
        tests_run++;
        if (first_c !== 4 || second_c !== 9) begin
            tests_failed++;
            $display("FAIL b2b_spacing: got cycles %0d,%0d want 4,9", first_c, second_c);
        end
        tests_run++;
        if (r1 !== 32'h99 || r2 !== 32'h99) begin
            tests_failed++;
            $display("FAIL b2b_data: got %h,%h want 00000099,00000099", r1, r2);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset;
        test_idle;
        test_store_load;
        test_wrap;
        test_abort;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
